// File: rtl/dice_light_if.sv
// Shared 3-bit dice/traffic-light bus together with the mode and roll controls
// that drive its source.
interface dice_light_if;
  logic       sel;
  logic       button;
  logic [2:0] data_in;

  modport master (output sel, output button, output data_in);
  modport slave  (input  sel, input  button, input  data_in);
endinterface

// File: rtl/dice_light_monitor.sv
// Receiving end of the dice/traffic-light bus: decodes each sample to a dice face
// or lamp drives, and checks code legality and sequence progression.
module dice_light_monitor #(
  parameter int unsigned LOCK_SAMPLES = 2,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  dice_light_if.slave          bus,
  output logic                 locked,
  output logic                 err_illegal,
  output logic                 err_seq,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [6:0]           seg,
  output logic                 red,
  output logic                 amber,
  output logic                 green
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_SAMPLES);

  state_t               state_reg, state_next;
  logic [3:0]           cnt_reg, cnt_next;
  logic [2:0]           prev_data_reg;
  logic                 prev_sel_reg;
  logic                 prev_button_reg;

  logic                 legal;
  logic                 match;
  logic                 mode_change;
  logic [2:0]           expected;
  logic                 err_illegal_next;
  logic                 err_seq_next;
  logic [6:0]           seg_next;
  logic [2:0]           lamp_next;
  logic [ERR_CNT_W-1:0] err_count_next;

  // Legality depends on the mode currently on the bus.
  always_comb begin
    legal = 1'b0;
    if (bus.sel) begin
      case (bus.data_in)
        3'b100, 3'b110, 3'b001, 3'b010: legal = 1'b1;
        default:                        legal = 1'b0;
      endcase
    end else begin
      legal = (bus.data_in != 3'b000) && (bus.data_in != 3'b111);
    end
  end

  // Successor predicted from last cycle's sample, mode and roll enable.
  always_comb begin
    expected = prev_data_reg;
    if (prev_sel_reg) begin
      case (prev_data_reg)
        3'b100:  expected = 3'b110;
        3'b110:  expected = 3'b001;
        3'b001:  expected = 3'b010;
        3'b010:  expected = 3'b100;
        default: expected = prev_data_reg;
      endcase
    end else if (prev_button_reg) begin
      expected = (prev_data_reg == 3'b110) ? 3'b001 : prev_data_reg + 3'd1;
    end
  end

  assign match       = (bus.data_in == expected);
  assign mode_change = (bus.sel != prev_sel_reg);

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    err_illegal_next = 1'b0;
    err_seq_next     = 1'b0;
    if (!legal) begin
      err_illegal_next = 1'b1;
      state_next       = IDLE;
      cnt_next         = 4'd0;
    end else if (state_reg == IDLE || mode_change) begin
      // Fresh start: the previous sample cannot predict this one.
      state_next = ACQ;
      cnt_next   = 4'd0;
    end else begin
      case (state_reg)
        ACQ: begin
          if (match) begin
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg + 4'd1 >= LOCK_CNT) begin
              state_next = LOCKED;
            end
          end else begin
            cnt_next = 4'd0;
          end
        end
        LOCKED: begin
          if (!match) begin
            err_seq_next = 1'b1;
            state_next   = ACQ;
            cnt_next     = 4'd0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    seg_next = 7'b0000000;
    if (!bus.sel && legal) begin
      case (bus.data_in)
        3'd1:    seg_next = 7'b0000110;
        3'd2:    seg_next = 7'b1011011;
        3'd3:    seg_next = 7'b1001111;
        3'd4:    seg_next = 7'b1100110;
        3'd5:    seg_next = 7'b1101101;
        3'd6:    seg_next = 7'b1111101;
        default: seg_next = 7'b0000000;
      endcase
    end
  end

  // Lamp bits map one-to-one onto the bus as {red, amber, green}.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lamp
    assign lamp_next[gi] = bus.sel && legal && bus.data_in[gi];
  end

  always_comb begin
    err_count_next = err_count;
    if ((err_illegal_next || err_seq_next) && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count_next = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      prev_data_reg   <= 3'b000;
      prev_sel_reg    <= 1'b0;
      prev_button_reg <= 1'b0;
      locked          <= 1'b0;
      err_illegal     <= 1'b0;
      err_seq         <= 1'b0;
      err_sticky      <= 1'b0;
      err_count       <= '0;
      seg             <= 7'b0000000;
      red             <= 1'b0;
      amber           <= 1'b0;
      green           <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      prev_data_reg   <= bus.data_in;
      prev_sel_reg    <= bus.sel;
      prev_button_reg <= bus.button;
      locked          <= (state_next == LOCKED);
      err_illegal     <= err_illegal_next;
      err_seq         <= err_seq_next;
      err_sticky      <= err_sticky | err_illegal_next | err_seq_next;
      err_count       <= err_count_next;
      seg             <= seg_next;
      red             <= lamp_next[2];
      amber           <= lamp_next[1];
      green           <= lamp_next[0];
    end
  end

endmodule

// File: tb/tb_dice_light_monitor.sv
// Directed bench for dice_light_monitor; a second instance with a 2-bit error
// counter watches the same bus to exercise saturation.
module tb_dice_light_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked, err_illegal, err_seq, err_sticky;
  logic [7:0] err_count;
  logic [6:0] seg;
  logic       red, amber, green;

  logic       s_locked, s_err_illegal, s_err_seq, s_err_sticky;
  logic [1:0] s_err_count;
  logic [6:0] s_seg;
  logic       s_red, s_amber, s_green;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  dice_light_if bus ();

  dice_light_monitor #(.LOCK_SAMPLES(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .locked(locked), .err_illegal(err_illegal), .err_seq(err_seq),
    .err_sticky(err_sticky), .err_count(err_count), .seg(seg),
    .red(red), .amber(amber), .green(green)
  );

  dice_light_monitor #(.LOCK_SAMPLES(2), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus),
    .locked(s_locked), .err_illegal(s_err_illegal), .err_seq(s_err_seq),
    .err_sticky(s_err_sticky), .err_count(s_err_count), .seg(s_seg),
    .red(s_red), .amber(s_amber), .green(s_green)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one sample, let the edge take it, then look at the outputs.
  task automatic step(input logic r, input logic s, input logic b, input logic [2:0] d);
    rst         = r;
    bus.sel     = s;
    bus.button  = b;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic lk, input logic ei, input logic es,
                            input logic st, input logic [7:0] cnt, input logic [6:0] sg,
                            input logic [2:0] rag);
    check({tag, ".locked"},      32'(locked),      32'(lk));
    check({tag, ".err_illegal"}, 32'(err_illegal), 32'(ei));
    check({tag, ".err_seq"},     32'(err_seq),     32'(es));
    check({tag, ".err_sticky"},  32'(err_sticky),  32'(st));
    check({tag, ".err_count"},   32'(err_count),   32'(cnt));
    check({tag, ".seg"},         32'(seg),         32'(sg));
    check({tag, ".lamps"},       32'({red, amber, green}), 32'(rag));
    $display("step %-4s locked=%0b ill=%0b seq=%0b sticky=%0b cnt=%0d seg=%07b rag=%03b",
             tag, locked, err_illegal, err_seq, err_sticky, err_count, seg, {red, amber, green});
  endtask

  initial begin
    rst = 1'b1; bus.sel = 1'b0; bus.button = 1'b0; bus.data_in = 3'b000;
    repeat (5) step(1'b1, 1'b0, 1'b0, 3'b000);
    expect_all("RST", 0, 0, 0, 0, 8'd0, 7'h00, 3'b000);
    check("RST.sat_count", 32'(s_err_count), 32'd0);

    // Dice roll: lock after two correct successors.
    step(0, 0, 1, 3'b001); expect_all("R1", 0, 0, 0, 0, 8'd0, 7'h06, 3'b000);
    step(0, 0, 1, 3'b010); expect_all("R2", 0, 0, 0, 0, 8'd0, 7'h5B, 3'b000);
    step(0, 0, 1, 3'b011); expect_all("R3", 1, 0, 0, 0, 8'd0, 7'h4F, 3'b000);

    // Hold: button low keeps the face.
    step(0, 0, 0, 3'b100); expect_all("H1", 1, 0, 0, 0, 8'd0, 7'h66, 3'b000);
    step(0, 0, 0, 3'b100); expect_all("H2", 1, 0, 0, 0, 8'd0, 7'h66, 3'b000);
    step(0, 0, 0, 3'b100); expect_all("H3", 1, 0, 0, 0, 8'd0, 7'h66, 3'b000);
    step(0, 0, 0, 3'b101); expect_all("H4", 0, 0, 1, 1, 8'd1, 7'h6D, 3'b000);

    // Relock, including the 6 -> 1 wrap.
    step(0, 0, 1, 3'b101); expect_all("L1", 0, 0, 0, 1, 8'd1, 7'h6D, 3'b000);
    step(0, 0, 1, 3'b110); expect_all("L2", 1, 0, 0, 1, 8'd1, 7'h7D, 3'b000);
    step(0, 0, 1, 3'b001); expect_all("L3", 1, 0, 0, 1, 8'd1, 7'h06, 3'b000);

    // Mode switch to traffic: no error, reacquire.
    step(0, 1, 1, 3'b010); expect_all("M1", 0, 0, 0, 1, 8'd1, 7'h00, 3'b010);
    step(0, 1, 1, 3'b100); expect_all("M2", 0, 0, 0, 1, 8'd1, 7'h00, 3'b100);
    step(0, 1, 0, 3'b110); expect_all("M3", 1, 0, 0, 1, 8'd1, 7'h00, 3'b110);
    step(0, 1, 0, 3'b001); expect_all("M4", 1, 0, 0, 1, 8'd1, 7'h00, 3'b001);
    step(0, 1, 1, 3'b010); expect_all("M5", 1, 0, 0, 1, 8'd1, 7'h00, 3'b010);

    // Back-to-back illegal codes in both modes.
    step(0, 1, 1, 3'b101); expect_all("I1", 0, 1, 0, 1, 8'd2, 7'h00, 3'b000);
    check("I1.sat_count", 32'(s_err_count), 32'd2);
    step(0, 1, 1, 3'b000); expect_all("I2", 0, 1, 0, 1, 8'd3, 7'h00, 3'b000);
    check("I2.sat_count", 32'(s_err_count), 32'd3);
    step(0, 0, 1, 3'b111); expect_all("I3", 0, 1, 0, 1, 8'd4, 7'h00, 3'b000);
    check("I3.sat_count", 32'(s_err_count), 32'd3);
    step(0, 0, 1, 3'b000); expect_all("I4", 0, 1, 0, 1, 8'd5, 7'h00, 3'b000);
    check("I4.sat_count", 32'(s_err_count), 32'd3);

    // Acquisition mismatch resets progress silently.
    step(0, 0, 1, 3'b011); expect_all("A1", 0, 0, 0, 1, 8'd5, 7'h4F, 3'b000);
    step(0, 0, 1, 3'b110); expect_all("A2", 0, 0, 0, 1, 8'd5, 7'h7D, 3'b000);
    step(0, 0, 1, 3'b001); expect_all("A3", 0, 0, 0, 1, 8'd5, 7'h06, 3'b000);
    step(0, 0, 1, 3'b010); expect_all("A4", 1, 0, 0, 1, 8'd5, 7'h5B, 3'b000);

    // Reset mid-stream, then tracking restarts from idle.
    step(1, 0, 1, 3'b011); expect_all("X1", 0, 0, 0, 0, 8'd0, 7'h00, 3'b000);
    check("X1.sat_count", 32'(s_err_count), 32'd0);
    step(0, 0, 1, 3'b100); expect_all("X2", 0, 0, 0, 0, 8'd0, 7'h66, 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
